// File: rtl/p6_controller_fsm.sv
// Instruction-sequencing controller for the simple datapath: latches an
// instruction on start and walks the register-file/ALU load/write sequence.
module p6_controller_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  aluop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG, S_WRITE_IMM
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    aluop    = 2'b00;
    shift    = 2'b00;
    illegal  = 1'b0;
    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == 3'b110 && op == 2'b10)      state_d = S_WRITE_IMM;
        else if (opcode == 3'b110 && op == 2'b00) state_d = S_GET_B;
        else if (opcode == 3'b101 && op == 2'b11) state_d = S_GET_B;
        else if (opcode == 3'b101)                state_d = S_GET_A;
        else begin
          illegal = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        // MOV reg reuses the ALU as a pass-through: A zeroed, ADD selected
        aluop = (opcode == 3'b101) ? op : 2'b00;
        asel  = (opcode == 3'b110) || (op == 2'b11);
        shift = sh;
        if (opcode == 3'b101 && op == 2'b01) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum = rd;
        vsel     = 2'b00;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = 2'b10;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_p6_controller_fsm.sv
// Bench: per-instruction expected output scripts compared cycle by cycle,
// directed scenarios followed by randomized instruction streams.
module tb_p6_controller_fsm;

  logic        clk = 1'b0;
  logic        reset, s;
  logic [15:0] instr;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, aluop, shift;
  logic [15:0] sximm8;

  p6_controller_fsm dut (
    .clk(clk), .reset(reset), .s(s), .instr(instr), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .aluop(aluop), .shift(shift),
    .sximm8(sximm8), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic [2:0] rdn, wrn;
    logic       wr, la, lb, lc, ls, as, bs;
    logic [1:0] vs, al, sh;
    logic [15:0] sx;
    logic       il;
  } ov_t;

  int    errs = 0, checks = 0;
  ov_t   exp_q[$];
  logic [15:0] m_ir = 16'h0;

  task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ov_t blank(input logic [15:0] ir);
    ov_t v;
    v = '0;
    v.sx = {{8{ir[7]}}, ir[7:0]};
    return v;
  endfunction

  // Expected busy-period script for one accepted instruction, one entry per cycle.
  task automatic load_script(input logic [15:0] ir);
    ov_t v;
    logic [2:0] opc;
    logic [1:0] op;
    bit movi, movr, mvn, alu3;
    opc  = ir[15:13];
    op   = ir[12:11];
    movi = (opc == 3'd6) && (op == 2'd2);
    movr = (opc == 3'd6) && (op == 2'd0);
    mvn  = (opc == 3'd5) && (op == 2'd3);
    alu3 = (opc == 3'd5) && (op != 2'd3);
    v = blank(ir);
    v.il = !(movi || movr || mvn || alu3);
    exp_q.push_back(v);
    if (movi) begin
      v = blank(ir); v.wrn = ir[10:8]; v.vs = 2'd2; v.wr = 1'b1;
      exp_q.push_back(v);
    end
    if (alu3) begin
      v = blank(ir); v.rdn = ir[10:8]; v.la = 1'b1;
      exp_q.push_back(v);
    end
    if (movr || mvn || alu3) begin
      v = blank(ir); v.rdn = ir[2:0]; v.lb = 1'b1;
      exp_q.push_back(v);
      v = blank(ir);
      v.al = movr ? 2'd0 : op;
      v.as = movr || mvn;
      v.sh = ir[4:3];
      if (alu3 && op == 2'd1) v.ls = 1'b1;
      else v.lc = 1'b1;
      exp_q.push_back(v);
      if (!(alu3 && op == 2'd1)) begin
        v = blank(ir); v.wrn = ir[7:5]; v.wr = 1'b1;
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic cyc(input logic r, input logic sv, input logic [15:0] iv, input string tag);
    ov_t e, g;
    reset = r; s = sv; instr = iv;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      m_ir = 16'h0;
    end else if (exp_q.size() == 0) begin
      if (sv) begin
        m_ir = iv;
        load_script(iv);
      end
    end else begin
      void'(exp_q.pop_front());
    end
    #1;
    if (exp_q.size() == 0) begin
      e = blank(m_ir);
      e.w = 1'b1;
    end else e = exp_q[0];
    g = '{w, readnum, writenum, write, loada, loadb, loadc, loads,
          asel, bsel, vsel, aluop, shift, sximm8, illegal};
    chk($sformatf("%s@%0t", tag, $time), g, e);
  endtask

  function automatic logic [15:0] rnd_instr();
    logic [15:0] x;
    x = 16'($urandom);
    case ($urandom_range(0, 4))
      0: x[15:13] = 3'b110;
      1, 2: x[15:13] = 3'b101;
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    cyc(1'b1, 1'b1, 16'hFFFF, "rst");
    cyc(1'b1, 1'b0, 16'h0, "rst");
    cyc(1'b0, 1'b0, 16'hD2FB, "idle");
    cyc(1'b0, 1'b1, 16'hD2FB, "movi");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, "movi");
    cyc(1'b0, 1'b1, 16'hA1A2, "add");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 16'hFFFF, "add");
    cyc(1'b0, 1'b1, 16'hA901, "cmp");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 16'hA901, "cmp");
    cyc(1'b0, 1'b0, 16'h0, "cmp");
    cyc(1'b0, 1'b1, 16'hE000, "ill");
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 16'h0, "ill");
    cyc(1'b0, 1'b1, 16'hA1A2, "rstmid");
    cyc(1'b0, 1'b0, 16'h0, "rstmid");
    cyc(1'b0, 1'b0, 16'h0, "rstmid");
    cyc(1'b1, 1'b0, 16'h0, "rstmid");
    cyc(1'b0, 1'b0, 16'h0, "rstmid");
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 16'hD2FB, "b2b");
    cyc(1'b0, 1'b1, 16'hC0B3, "movr");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0, "movr");
    cyc(1'b0, 1'b1, 16'hB85A, "mvn");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0, "mvn");
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 2) != 0), rnd_instr(), "rnd");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
